// File: rtl/alu_pkg.sv
// Shared types for the UART-driven ALU command controller: ALU opcodes,
// command bytes and controller states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_MUL   = 4'h2,
    ALU_DIV   = 4'h3,
    ALU_AND   = 4'h4,
    ALU_OR    = 4'h5,
    ALU_NAND  = 4'h6,
    ALU_NOR   = 4'h7,
    ALU_XOR   = 4'h8,
    ALU_XNOR  = 4'h9,
    ALU_CMPEQ = 4'hA,
    ALU_CMPGT = 4'hB,
    ALU_CMPLT = 4'hC,
    ALU_SHR   = 4'hD,
    ALU_SHL   = 4'hE,
    ALU_NOP   = 4'hF
  } alu_op_e;

  localparam logic [7:0] CMD_OP_WITH_OPS = 8'hCC;
  localparam logic [7:0] CMD_OP_NO_OPS   = 8'hDD;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_RUN,
    WAIT_RES,
    SEND_LO,
    SEND_HI
  } ctrl_state_e;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Command controller: collects operands and an opcode from UART RX, fires
// the ALU once, and returns the result to UART TX as low byte then high byte.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output alu_op_e               ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CTRL_BUSY
);

  localparam logic [DATA_WIDTH-1:0] CmdWithOps = DATA_WIDTH'(CMD_OP_WITH_OPS);
  localparam logic [DATA_WIDTH-1:0] CmdNoOps   = DATA_WIDTH'(CMD_OP_NO_OPS);

  ctrl_state_e          state_q;
  logic [OUT_WIDTH-1:0] result_q;

  // TX byte is a pure select of the captured result, so it cannot move while TX is busy.
  always_comb begin
    TX_P_DATA = (state_q == SEND_HI) ? result_q[DATA_WIDTH +: DATA_WIDTH]
                                     : result_q[DATA_WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= ALU_ADD;
      ALU_EN    <= 1'b0;
      TX_D_VLD  <= 1'b0;
      CTRL_BUSY <= 1'b0;
      result_q  <= '0;
    end else begin
      ALU_EN <= 1'b0;
      case (state_q)
        IDLE: begin
          if (RX_D_VLD && RX_P_DATA == CmdWithOps) begin
            state_q   <= GET_A;
            CTRL_BUSY <= 1'b1;
          end else if (RX_D_VLD && RX_P_DATA == CmdNoOps) begin
            state_q   <= GET_FUN;
            CTRL_BUSY <= 1'b1;
          end
        end
        GET_A: begin
          if (RX_D_VLD) begin
            ALU_A   <= RX_P_DATA;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (RX_D_VLD) begin
            ALU_B   <= RX_P_DATA;
            state_q <= GET_FUN;
          end
        end
        GET_FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN <= alu_op_e'(RX_P_DATA[3:0]);
            ALU_EN  <= 1'b1;
            state_q <= ALU_RUN;
          end
        end
        ALU_RUN: begin
          state_q <= WAIT_RES;
        end
        WAIT_RES: begin
          if (ALU_OUT_VALID) begin
            result_q <= ALU_OUT;
            TX_D_VLD <= 1'b1;
            state_q  <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (!TX_BUSY) begin
            state_q <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (!TX_BUSY) begin
            TX_D_VLD  <= 1'b0;
            CTRL_BUSY <= 1'b0;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomised self-checking bench for alu_cmd_ctrl with a behavioural ALU and
// a frame-level reference model of the command protocol.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       resetN;
  logic [7:0] rxData;
  logic       rxValid;
  logic [7:0] aluA;
  logic [7:0] aluB;
  alu_op_e    aluFun;
  logic       aluEn;
  logic [15:0] aluOut;
  logic       aluOutValid;
  logic [7:0] txData;
  logic       txValid;
  logic       txBusy;
  logic       ctrlBusy;

  int vectorCount = 0;
  int missCount   = 0;
  logic [7:0] modelA = 8'h00;
  logic [7:0] modelB = 8'h00;

  alu_cmd_ctrl #(.DATA_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK(clock), .RST(resetN),
    .RX_P_DATA(rxData), .RX_D_VLD(rxValid),
    .ALU_A(aluA), .ALU_B(aluB), .ALU_FUN(aluFun), .ALU_EN(aluEn),
    .ALU_OUT(aluOut), .ALU_OUT_VALID(aluOutValid),
    .TX_P_DATA(txData), .TX_D_VLD(txValid), .TX_BUSY(txBusy),
    .CTRL_BUSY(ctrlBusy)
  );

  always #5 clock = ~clock;

  // What the ALU is supposed to compute for each opcode, 16-bit result.
  function automatic logic [15:0] aluRef(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] x;
    logic [15:0] y;
    x = {8'h00, a};
    y = {8'h00, b};
    case (op)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x * y;
      4'h3: return (y == 16'h0) ? 16'h0 : x / y;
      4'h4: return x & y;
      4'h5: return x | y;
      4'h6: return {8'h00, ~(a & b)};
      4'h7: return {8'h00, ~(a | b)};
      4'h8: return x ^ y;
      4'h9: return {8'h00, ~(a ^ b)};
      4'hA: return (a == b) ? 16'h1 : 16'h0;
      4'hB: return (a > b) ? 16'h1 : 16'h0;
      4'hC: return (a < b) ? 16'h1 : 16'h0;
      4'hD: return x >> 1;
      4'hE: return x << 1;
      default: return 16'h0;
    endcase
  endfunction

  // Registered ALU: one cycle from enable to a qualified result.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      aluOut      <= 16'h0;
      aluOutValid <= 1'b0;
    end else begin
      aluOutValid <= aluEn;
      if (aluEn) aluOut <= aluRef(aluFun, aluA, aluB);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one RX byte for a single cycle after a random idle gap; starts and ends on a negedge.
  task automatic applyStimulus(input logic [7:0] d);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    rxData  = d;
    rxValid = 1'b1;
    @(negedge clock);
    rxValid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_A"}, aluA, 0);
    checkOutput({tag, "_B"}, aluB, 0);
    checkOutput({tag, "_FUN"}, aluFun, 0);
    checkOutput({tag, "_EN"}, aluEn, 0);
    checkOutput({tag, "_TXD"}, txData, 0);
    checkOutput({tag, "_TXV"}, txValid, 0);
    checkOutput({tag, "_BUSY"}, ctrlBusy, 0);
  endtask

  task automatic runFrame(input bit withOps, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] fun, input int busyLo, input int busyHi, input bit inject);
    logic [15:0] expRes;
    applyStimulus(withOps ? CMD_OP_WITH_OPS : CMD_OP_NO_OPS);
    checkOutput("busyAfterCmd", ctrlBusy, 1);
    if (withOps) begin
      applyStimulus(a);
      applyStimulus(b);
      modelA = a;
      modelB = b;
    end
    expRes = aluRef(fun, modelA, modelB);
    applyStimulus({4'($urandom), fun});
    checkOutput("aluEnPulse", aluEn, 1);
    checkOutput("aluA", aluA, modelA);
    checkOutput("aluB", aluB, modelB);
    checkOutput("aluFun", aluFun, fun);
    checkOutput("txIdleRun", txValid, 0);
    if (inject) begin
      rxData  = CMD_OP_WITH_OPS;
      rxValid = 1'b1;
    end
    @(negedge clock);
    rxValid = 1'b0;
    checkOutput("aluEnLow", aluEn, 0);
    checkOutput("txIdleWait", txValid, 0);
    @(negedge clock);
    checkOutput("txLatency", txValid, 1);
    checkOutput("txLo", txData, expRes[7:0]);
    repeat (busyLo) begin
      txBusy = 1'b1;
      @(negedge clock);
      checkOutput("txLoHoldVld", txValid, 1);
      checkOutput("txLoHoldData", txData, expRes[7:0]);
    end
    txBusy = 1'b0;
    if (inject) begin
      rxData  = CMD_OP_WITH_OPS;
      rxValid = 1'b1;
    end
    @(negedge clock);
    rxValid = 1'b0;
    checkOutput("txHiVld", txValid, 1);
    checkOutput("txHi", txData, expRes[15:8]);
    repeat (busyHi) begin
      txBusy = 1'b1;
      @(negedge clock);
      checkOutput("txHiHoldVld", txValid, 1);
      checkOutput("txHiHoldData", txData, expRes[15:8]);
    end
    txBusy = 1'b0;
    @(negedge clock);
    checkOutput("txDone", txValid, 0);
    checkOutput("idleAfterFrame", ctrlBusy, 0);
    checkOutput("aluEnIdle", aluEn, 0);
  endtask

  initial begin
    logic [7:0] junk;
    resetN  = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    txBusy  = 1'b0;
    repeat (2) @(negedge clock);
    checkAllZero("reset");
    resetN = 1'b1;
    @(negedge clock);

    runFrame(1'b1, 8'h05, 8'h03, 4'h0, 0, 0, 1'b0);
    runFrame(1'b0, 8'h00, 8'h00, 4'h1, 0, 0, 1'b0);
    runFrame(1'b1, 8'hFF, 8'hFF, 4'h2, 0, 0, 1'b0);
    runFrame(1'b1, 8'h12, 8'h34, 4'h0, 5, 0, 1'b0);

    applyStimulus(8'h12);
    checkOutput("junkIgnored", ctrlBusy, 0);
    runFrame(1'b1, 8'h21, 8'h07, 4'h8, 0, 1, 1'b1);

    // Reset in the middle of an operand frame.
    applyStimulus(CMD_OP_WITH_OPS);
    applyStimulus(8'h05);
    #2 resetN = 1'b0;
    #1 checkAllZero("midFrameRst");
    modelA = 8'h00;
    modelB = 8'h00;
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    runFrame(1'b1, 8'h05, 8'h03, 4'h0, 0, 0, 1'b0);

    // Reset while the low byte is stalled by TX.
    txBusy = 1'b1;
    applyStimulus(CMD_OP_WITH_OPS);
    applyStimulus(8'h40);
    applyStimulus(8'h02);
    applyStimulus(8'h02);
    repeat (2) @(negedge clock);
    checkOutput("stallBeforeRst", txValid, 1);
    #2 resetN = 1'b0;
    #1 checkAllZero("midTxRst");
    modelA = 8'h00;
    modelB = 8'h00;
    @(negedge clock);
    resetN = 1'b1;
    txBusy = 1'b0;
    repeat (4) begin
      @(negedge clock);
      checkOutput("noTxAfterRst", txValid, 0);
    end

    for (int i = 0; i < 25; i++) begin
      junk = 8'($urandom);
      if (junk == CMD_OP_WITH_OPS || junk == CMD_OP_NO_OPS) junk = junk ^ 8'h01;
      applyStimulus(junk);
      checkOutput("randJunk", ctrlBusy, 0);
      runFrame($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 4'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
